// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse_gen
// Purpose  : Push-button conditioner. The raw pin is synchronised, the press
//            and the release are both debounced, and one single-cycle step
//            pulse is emitted for each accepted press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_pulse,
   output logic btn_level
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESS_CHK = 2'd1,
      S_PRESSED   = 2'd2,
      S_REL_CHK   = 2'd3
   } state_t;

   // Last count value of a qualification window; reaching it ends the window.
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_p;
   logic             r_s1;
   logic             r_s;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   state_t           r_state;
   state_t           w_state_next;
   logic             w_pulse_next;
   logic             w_level_next;

   // Normalise polarity so that 1 always means "pressed" from here on.
   assign w_p = btn_raw ^ ACTIVE_LOW;

   // Two-flop synchroniser for the asynchronous pin; resets to "not pressed".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s  <= 1'b0;
      end else begin
         r_s1 <= w_p;
         r_s  <= r_s1;
      end
   end

   // State, counter and registered outputs update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         btn_pulse <= 1'b0;
         btn_level <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         btn_pulse <= w_pulse_next;
         btn_level <= w_level_next;
      end
   end

   // Next-state, counter and output decode; the counter restarts on any move.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pulse_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_s) w_state_next = S_PRESS_CHK;
         end
         S_PRESS_CHK: begin
            if (!r_s) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == c_cnt_max) begin
               w_state_next = S_PRESSED;
               w_pulse_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_PRESSED: begin
            if (!r_s) w_state_next = S_REL_CHK;
         end
         S_REL_CHK: begin
            if (r_s) begin
               w_state_next = S_PRESSED;
            end else if (r_cnt == c_cnt_max) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (w_state_next != r_state) w_cnt_next = '0;
      w_level_next = (w_state_next == S_PRESSED) || (w_state_next == S_REL_CHK);
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_pulse_gen
// Purpose  : Directed bench for btn_pulse_gen with DEBOUNCE_CYCLES=4; one
//            active-high instance and one active-low instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

   logic clk = 1'b0;
   logic reset;
   logic raw0, raw1;
   logic pulse0, level0, pulse1, level1;
   int   passed = 0;
   int   total  = 0;
   int   npulse0 = 0;
   int   npulse1 = 0;

   btn_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LOW(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .btn_raw(raw0),
      .btn_pulse(pulse0), .btn_level(level0)
   );

   btn_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .ACTIVE_LOW(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .btn_raw(raw1),
      .btn_pulse(pulse1), .btn_level(level1)
   );

   always #5 clk = ~clk;

   // Pulse tallies sampled mid-cycle.
   always @(negedge clk) begin
      if (pulse0 === 1'b1) npulse0 = npulse0 + 1;
      if (pulse1 === 1'b1) npulse1 = npulse1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int lvl_bad;
      reset = 1'b1;
      raw0  = 1'b0;
      raw1  = 1'b1;
      #1;
      check("reset_pulse0", 32'(pulse0), 0);
      check("reset_level0", 32'(level0), 0);
      check("reset_pulse1", 32'(pulse1), 0);
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Clean press: pin high sampled from edge 0.
      raw0 = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         check($sformatf("clean_pulse_e%0d", e), 32'(pulse0), 32'(e == 6));
         check($sformatf("clean_level_e%0d", e), 32'(level0), 32'(e >= 6));
      end
      // Clean release sampled from edge 20.
      raw0 = 1'b0;
      for (int e = 20; e < 31; e++) begin
         tick();
         check($sformatf("rel_pulse_e%0d", e), 32'(pulse0), 0);
         check($sformatf("rel_level_e%0d", e), 32'(level0), 32'(e < 26));
      end

      // Bounce rejection: 1,0,1,0 for two cycles each, then hold high.
      for (int i = 0; i < 4; i++) begin
         raw0 = (i % 2 == 0);
         repeat (2) begin
            tick();
            check("bounce_no_pulse", 32'(pulse0), 0);
            check("bounce_no_level", 32'(level0), 0);
         end
      end
      base = npulse0;
      raw0 = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("bounce_pulse_e%0d", e), 32'(pulse0), 32'(e == 6));
      end
      check("bounce_pulse_count", 32'(npulse0 - base), 1);

      // Release bounce: low for three cycles while pressed.
      base = npulse0;
      raw0 = 1'b0;
      repeat (3) tick();
      raw0 = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         check("relbounce_level", 32'(level0), 1);
         check("relbounce_pulse", 32'(pulse0), 0);
      end
      check("relbounce_count", 32'(npulse0 - base), 0);
      raw0 = 1'b0;
      repeat (8) tick();
      check("relbounce_released", 32'(level0), 0);
      raw0 = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("repress_pulse_e%0d", e), 32'(pulse0), 32'(e == 6));
      end
      check("repress_count", 32'(npulse0 - base), 1);

      // Long hold of 1000 cycles from idle.
      raw0 = 1'b0;
      repeat (10) tick();
      check("hold_idle_level", 32'(level0), 0);
      base    = npulse0;
      lvl_bad = 0;
      raw0    = 1'b1;
      for (int e = 0; e < 1000; e++) begin
         tick();
         if (e >= 6 && level0 !== 1'b1) lvl_bad++;
      end
      check("hold_pulse_count", 32'(npulse0 - base), 1);
      check("hold_level_drops", 32'(lvl_bad), 0);

      // Reset while in PRESS_CHK with the count at 2.
      raw0 = 1'b0;
      repeat (10) tick();
      base = npulse0;
      raw0 = 1'b1;
      repeat (5) tick();            // edges 0..4: count reaches 2
      reset = 1'b1;
      #1;
      check("midreset_pulse", 32'(pulse0), 0);
      check("midreset_level", 32'(level0), 0);
      repeat (3) begin
         tick();
         check("inreset_pulse", 32'(pulse0), 0);
      end
      reset = 1'b0;
      check("midreset_no_pulse", 32'(npulse0 - base), 0);
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("postreset_pulse_e%0d", e), 32'(pulse0), 32'(e == 6));
      end
      check("postreset_count", 32'(npulse0 - base), 1);

      // Active-low instance: idle high throughout so far, then low for 10.
      check("al_idle_count", 32'(npulse1), 0);
      raw0 = 1'b0;
      raw1 = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         check($sformatf("al_pulse_e%0d", e), 32'(pulse1), 32'(e == 6));
         check($sformatf("al_level_e%0d", e), 32'(level1), 32'(e >= 6));
      end
      raw1 = 1'b1;
      for (int e = 10; e < 22; e++) begin
         tick();
         check($sformatf("al_rel_pulse_e%0d", e), 32'(pulse1), 0);
         check($sformatf("al_rel_level_e%0d", e), 32'(level1), 32'(e < 16));
      end
      check("al_pulse_count", 32'(npulse1), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
